// File: rtl/flash_addr_sample_unit.sv
// Flash word-address counter plus 32-bit word to two 16-bit audio sample splitter.
// Define FLASH_ADDR_LOOP_EN to wrap the address at the song boundaries instead of stopping.
module flash_addr_sample_unit #(
  parameter int unsigned ADDR_W = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR = 23'h07FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_reset_n,
  input  logic              inc_address,
  input  logic              direction,
  input  logic              flash_mem_readdatavalid,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              sync_clk,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [15:0]       audio_sample,
  output logic              sample_strobe,
  output logic              word_done,
  output logic              end_of_song,
  output logic              overrun
);

  typedef enum logic [1:0] {StEmpty, StFirst, StSecond} state_e;

  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic              rev_q, rev_d;
  logic [15:0]       sample_q, sample_d;
  logic              strobe_q, strobe_d;
  logic              word_done_q, word_done_d;
  logic              eos_q, eos_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_d      = word_q;
    rev_d       = rev_q;
    sample_d    = sample_q;
    strobe_d    = 1'b0;
    word_done_d = 1'b0;
    overrun_d   = overrun_q;
`ifdef FLASH_ADDR_LOOP_EN
    eos_d       = 1'b0;
`else
    eos_d       = eos_q;
`endif
    if (!addr_reset_n) begin
      addr_d    = direction ? START_ADDR : END_ADDR;
      state_d   = StEmpty;
      eos_d     = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (inc_address) begin
`ifdef FLASH_ADDR_LOOP_EN
        if (direction) begin
          if (addr_q == END_ADDR) begin
            addr_d = START_ADDR;
            eos_d  = 1'b1;
          end else begin
            addr_d = addr_q + AddrOne;
          end
        end else begin
          if (addr_q == START_ADDR) begin
            addr_d = END_ADDR;
            eos_d  = 1'b1;
          end else begin
            addr_d = addr_q - AddrOne;
          end
        end
`else
        // Once the boundary is hit the counter is frozen until a restart.
        if (!eos_q) begin
          if (direction) begin
            if (addr_q == END_ADDR) eos_d = 1'b1;
            else addr_d = addr_q + AddrOne;
          end else begin
            if (addr_q == START_ADDR) eos_d = 1'b1;
            else addr_d = addr_q - AddrOne;
          end
        end
`endif
      end
      unique case (state_q)
        StEmpty: begin
          if (flash_mem_readdatavalid) begin
            word_d  = flash_mem_readdata;
            rev_d   = ~direction;
            state_d = StFirst;
          end
        end
        StFirst: begin
          if (sync_clk) begin
            sample_d = rev_q ? word_q[31:16] : word_q[15:0];
            strobe_d = 1'b1;
            state_d  = StSecond;
          end
          if (flash_mem_readdatavalid) overrun_d = 1'b1;
        end
        StSecond: begin
          if (sync_clk) begin
            sample_d    = rev_q ? word_q[15:0] : word_q[31:16];
            strobe_d    = 1'b1;
            word_done_d = 1'b1;
            state_d     = StEmpty;
          end
          if (flash_mem_readdatavalid) overrun_d = 1'b1;
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StEmpty;
      addr_q      <= START_ADDR;
      word_q      <= 32'h0;
      rev_q       <= 1'b0;
      sample_q    <= 16'h0;
      strobe_q    <= 1'b0;
      word_done_q <= 1'b0;
      eos_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      rev_q       <= rev_d;
      sample_q    <= sample_d;
      strobe_q    <= strobe_d;
      word_done_q <= word_done_d;
      eos_q       <= eos_d;
      overrun_q   <= overrun_d;
    end
  end

  assign flash_mem_address = addr_q;
  assign audio_sample      = sample_q;
  assign sample_strobe     = strobe_q;
  assign word_done         = word_done_q;
  assign end_of_song       = eos_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_flash_addr_sample_unit.sv
// Directed plus random bench for flash_addr_sample_unit against a queue-based sample model.
module tb_flash_addr_sample_unit;

  localparam int StartA = 'h000000;
  localparam int EndA   = 'h07FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        addr_reset_n = 1'b1;
  logic        inc_address = 1'b0;
  logic        direction = 1'b1;
  logic        flash_mem_readdatavalid = 1'b0;
  logic [31:0] flash_mem_readdata = 32'h0;
  logic        sync_clk = 1'b0;
  logic [22:0] flash_mem_address;
  logic [15:0] audio_sample;
  logic        sample_strobe;
  logic        word_done;
  logic        end_of_song;
  logic        overrun;

  flash_addr_sample_unit dut (
    .clk                     (clk),
    .reset                   (reset),
    .addr_reset_n            (addr_reset_n),
    .inc_address             (inc_address),
    .direction               (direction),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .flash_mem_readdata      (flash_mem_readdata),
    .sync_clk                (sync_clk),
    .flash_mem_address       (flash_mem_address),
    .audio_sample            (audio_sample),
    .sample_strobe           (sample_strobe),
    .word_done               (word_done),
    .end_of_song             (end_of_song),
    .overrun                 (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: address as an integer, pending samples as a FIFO of halves.
  int          m_addr = StartA;
  logic [15:0] m_q[$];
  logic [15:0] m_sample = 16'h0;
  logic        m_strobe = 1'b0;
  logic        m_wd = 1'b0;
  logic        m_eos = 1'b0;
  logic        m_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".addr"}, {9'h0, flash_mem_address}, m_addr);
    chk({tag, ".sample"}, {16'h0, audio_sample}, {16'h0, m_sample});
    chk({tag, ".strobe"}, {31'h0, sample_strobe}, {31'h0, m_strobe});
    chk({tag, ".word_done"}, {31'h0, word_done}, {31'h0, m_wd});
    chk({tag, ".eos"}, {31'h0, end_of_song}, {31'h0, m_eos});
    chk({tag, ".overrun"}, {31'h0, overrun}, {31'h0, m_ovr});
  endtask

  task automatic step(input string tag, input logic ar, input logic inc, input logic dir,
                      input logic rdv, input logic [31:0] data, input logic sync);
    bit busy;
    addr_reset_n            = ar;
    inc_address             = inc;
    direction               = dir;
    flash_mem_readdatavalid = rdv;
    flash_mem_readdata      = data;
    sync_clk                = sync;
    @(posedge clk);
    #1;
    m_strobe = 1'b0;
    m_wd     = 1'b0;
`ifdef FLASH_ADDR_LOOP_EN
    m_eos = 1'b0;
`endif
    if (!ar) begin
      m_addr = dir ? StartA : EndA;
      m_q.delete();
      m_eos = 1'b0;
      m_ovr = 1'b0;
    end else begin
      if (inc) begin
`ifdef FLASH_ADDR_LOOP_EN
        if (dir) begin
          if (m_addr == EndA) begin m_addr = StartA; m_eos = 1'b1; end
          else m_addr = m_addr + 1;
        end else begin
          if (m_addr == StartA) begin m_addr = EndA; m_eos = 1'b1; end
          else m_addr = m_addr - 1;
        end
`else
        if (!m_eos) begin
          if (dir) begin
            if (m_addr == EndA) m_eos = 1'b1;
            else m_addr = m_addr + 1;
          end else begin
            if (m_addr == StartA) m_eos = 1'b1;
            else m_addr = m_addr - 1;
          end
        end
`endif
      end
      busy = (m_q.size() != 0);
      if (sync && busy) begin
        m_sample = m_q.pop_front();
        m_strobe = 1'b1;
        m_wd     = (m_q.size() == 0);
      end
      if (rdv) begin
        if (busy) m_ovr = 1'b1;
        else if (dir) begin m_q.push_back(data[15:0]); m_q.push_back(data[31:16]); end
        else begin m_q.push_back(data[31:16]); m_q.push_back(data[15:0]); end
      end
    end
    chk_all(tag);
  endtask

  initial begin
    logic dir_r;
    #12;
    chk_all("reset");
    @(negedge clk);
    reset = 1'b1;

    step("ar_fwd", 0, 0, 1, 0, 32'h0, 0);
    chk("ar_fwd_addr", {9'h0, flash_mem_address}, 32'h000000);
    step("ar_rev", 0, 0, 0, 0, 32'h0, 0);
    chk("ar_rev_addr", {9'h0, flash_mem_address}, 32'h07FFFF);

    step("fwd_ar", 0, 0, 1, 0, 32'h0, 0);
    step("fwd_load", 1, 0, 1, 1, 32'hAAAA5555, 0);
    step("fwd_s1", 1, 0, 1, 0, 32'h0, 1);
    chk("fwd_s1_val", {16'h0, audio_sample}, 32'h5555);
    step("fwd_s2", 1, 0, 1, 0, 32'h0, 1);
    chk("fwd_s2_val", {16'h0, audio_sample}, 32'hAAAA);
    chk("fwd_s2_wd", {31'h0, word_done}, 32'h1);

    step("rev_load", 1, 0, 0, 1, 32'hAAAA5555, 0);
    step("rev_s1", 1, 0, 0, 0, 32'h0, 1);
    chk("rev_s1_val", {16'h0, audio_sample}, 32'hAAAA);
    step("rev_s2_flip", 1, 0, 1, 0, 32'h0, 1);
    chk("rev_s2_val", {16'h0, audio_sample}, 32'h5555);

    step("bnd_ar", 0, 0, 0, 0, 32'h0, 0);
    step("bnd_inc_fwd", 1, 1, 1, 0, 32'h0, 0);
`ifdef FLASH_ADDR_LOOP_EN
    chk("bnd_fwd_wrap", {9'h0, flash_mem_address}, 32'h000000);
`else
    chk("bnd_fwd_hold", {9'h0, flash_mem_address}, 32'h07FFFF);
`endif
    chk("bnd_fwd_eos", {31'h0, end_of_song}, 32'h1);
    step("bnd_idle", 1, 0, 1, 0, 32'h0, 0);
    step("bnd_inc2", 1, 1, 0, 0, 32'h0, 0);
    step("bnd_ar2", 0, 0, 1, 0, 32'h0, 0);
    step("bnd_inc_rev", 1, 1, 0, 0, 32'h0, 0);
    step("bnd_idle2", 1, 0, 0, 0, 32'h0, 0);

    step("ovr_ar", 0, 0, 1, 0, 32'h0, 0);
    step("ovr_load", 1, 0, 1, 1, 32'hAAAA5555, 0);
    step("ovr_second", 1, 0, 1, 1, 32'h12345678, 0);
    chk("ovr_set", {31'h0, overrun}, 32'h1);
    step("ovr_s1", 1, 0, 1, 0, 32'h0, 1);
    chk("ovr_s1_val", {16'h0, audio_sample}, 32'h5555);
    step("ovr_clear", 0, 0, 1, 0, 32'h0, 0);
    chk("ovr_cleared", {31'h0, overrun}, 32'h0);

    step("pri_load", 1, 0, 1, 1, 32'hCAFEBEEF, 0);
    step("pri_s1", 1, 0, 1, 0, 32'h0, 1);
    step("pri_all", 0, 1, 1, 0, 32'h0, 1);
    chk("pri_no_strobe", {31'h0, sample_strobe}, 32'h0);
    chk("pri_no_wd", {31'h0, word_done}, 32'h0);
    chk("pri_sample_hold", {16'h0, audio_sample}, 32'hBEEF);
    step("pri_empty_sync", 1, 0, 1, 0, 32'h0, 1);

    dir_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) dir_r = ~dir_r;
      step("rand", $urandom_range(15) != 0, $urandom_range(3) == 0, dir_r,
           $urandom_range(3) == 0, $urandom, $urandom_range(2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
